// File: rtl/grant_sched_pkg.sv
// grant_sched_pkg
//   Shared definitions for the grant/response burst scheduler:
//   default burst length and starvation threshold, the lock FSM state
//   encoding and a width helper that never returns zero.
package grant_sched_pkg;

  localparam int BEATS_DEF    = 8;
  localparam int MAX_WAIT_DEF = 15;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // ceil(log2(v)), clamped to at least 1 so vectors are never zero-width
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/grant_burst_scheduler_rr_pick.sv
// rr_pick
//   Rotating-priority picker. Returns the first set bit of 'valid' strictly
//   above index 'last', wrapping to the lowest set bit when nothing above is
//   set. With last = N-1 this degenerates to a plain lowest-index pick.
//   When nothing is valid, 'pick' echoes 'last' and 'any' is low.
// Ports
//   valid  in   N    candidate vector
//   last   in   IW   previously granted index
//   pick   out  IW   selected index
//   any    out  1    at least one candidate valid
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] pick,
  output logic          any
);

  logic found;

  assign any = |valid;

  // Scan last+1, last+2, ... wrapping; last itself is visited last, which
  // makes the wrap-around portion a lowest-index-first search.
  always_comb begin
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && valid[(int'(last) + k) % N]) begin
        pick  = IW'((int'(last) + k) % N);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/grant_burst_scheduler.sv
// grant_burst_scheduler
//   Shares one grant/response output channel among N_IN requesters.
//   Round-robin arbitration with a starvation guard; a multi-beat message
//   locks the channel to its requester until all BEATS beats transfer.
//   The datapath is purely combinational (no buffering, 0-cycle latency).
// Ports
//   clk           in   1               clock
//   reset         in   1               synchronous, active-high
//   in_valid      in   N_IN            request valid per requester
//   in_ready      out  N_IN            request accepted when valid&ready
//   in_multibeat  in   N_IN            message carries BEATS beats
//   in_payload    in   N_IN*PAYLOAD_W  requester i at [i*PAYLOAD_W +: PAYLOAD_W]
//   out_valid     out  1               selected requester valid
//   out_ready     in   1               downstream accept
//   out_payload   out  PAYLOAD_W       selected payload
//   out_chosen    out  clog2(N_IN)     selected requester index
//   out_locked    out  1               burst lock held
module grant_burst_scheduler
  import grant_sched_pkg::*;
#(
  parameter int N_IN      = 4,
  parameter int PAYLOAD_W = 76,
  parameter int BEATS     = BEATS_DEF,
  parameter int MAX_WAIT  = MAX_WAIT_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_IN-1:0]           in_valid,
  output logic [N_IN-1:0]           in_ready,
  input  logic [N_IN-1:0]           in_multibeat,
  input  logic [N_IN*PAYLOAD_W-1:0] in_payload,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PAYLOAD_W-1:0]      out_payload,
  output logic [clog2_min1(N_IN)-1:0] out_chosen,
  output logic                      out_locked
);

  localparam int IW = clog2_min1(N_IN);
  localparam int BW = clog2_min1(BEATS);
  localparam int WW = clog2_min1(MAX_WAIT + 1);

  state_t          state_reg, state_next;
  logic [BW-1:0]   beat_cnt_reg, beat_cnt_next;
  logic [IW-1:0]   lock_idx_reg, lock_idx_next;
  logic [IW-1:0]   last_grant_reg;
  logic [IW-1:0]   chosen;
  logic [IW-1:0]   rr_idx, starve_idx;
  logic            rr_any, starve_any;
  logic [N_IN-1:0] starve_vec;
  logic            fire;

  logic [PAYLOAD_W-1:0] payload_arr [N_IN];

  // Per-requester wait counters, starvation flags, payload unpacking and
  // ready decode.
  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_req
      logic [WW-1:0] wait_cnt_reg;

      assign payload_arr[gi] = in_payload[gi*PAYLOAD_W +: PAYLOAD_W];
      assign starve_vec[gi]  = in_valid[gi] && (wait_cnt_reg == WW'(MAX_WAIT));
      assign in_ready[gi]    = out_ready && (chosen == IW'(gi));

      // Keeps counting during a lock so a long burst can push others into
      // forced priority as soon as the lock releases.
      always_ff @(posedge clk) begin
        if (reset) begin
          wait_cnt_reg <= '0;
        end else if (!in_valid[gi] || (fire && (chosen == IW'(gi)))) begin
          wait_cnt_reg <= '0;
        end else if (wait_cnt_reg != WW'(MAX_WAIT)) begin
          wait_cnt_reg <= wait_cnt_reg + WW'(1);
        end
      end
    end
  endgenerate

  rr_pick #(.N(N_IN), .IW(IW)) u_rr_pick (
    .valid (in_valid),
    .last  (last_grant_reg),
    .pick  (rr_idx),
    .any   (rr_any)
  );

  // Anchoring at N_IN-1 turns the rotating picker into lowest-index-first.
  rr_pick #(.N(N_IN), .IW(IW)) u_starve_pick (
    .valid (starve_vec),
    .last  (IW'(N_IN - 1)),
    .pick  (starve_idx),
    .any   (starve_any)
  );

  always_comb begin
    chosen = last_grant_reg;
    if (state_reg == ST_LOCKED) begin
      chosen = lock_idx_reg;
    end else if (starve_any) begin
      chosen = starve_idx;
    end else if (rr_any) begin
      chosen = rr_idx;
    end
  end

  assign out_chosen  = chosen;
  assign out_valid   = in_valid[chosen];
  assign out_payload = payload_arr[chosen];
  assign out_locked  = (state_reg == ST_LOCKED);
  assign fire        = out_valid && out_ready;

  // Lock FSM: the first beat is carried in IDLE, so entering LOCKED starts
  // the beat count at 1 and the lock releases on beat BEATS.
  always_comb begin
    state_next    = state_reg;
    beat_cnt_next = beat_cnt_reg;
    lock_idx_next = lock_idx_reg;
    case (state_reg)
      ST_IDLE: begin
        if (fire && in_multibeat[chosen] && (BEATS > 1)) begin
          state_next    = ST_LOCKED;
          lock_idx_next = chosen;
          beat_cnt_next = BW'(1);
        end
      end
      ST_LOCKED: begin
        if (fire) begin
          if (beat_cnt_reg == BW'(BEATS - 1)) begin
            state_next    = ST_IDLE;
            beat_cnt_next = '0;
          end else begin
            beat_cnt_next = beat_cnt_reg + BW'(1);
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      beat_cnt_reg   <= '0;
      lock_idx_reg   <= '0;
      last_grant_reg <= IW'(N_IN - 1);
    end else begin
      state_reg    <= state_next;
      beat_cnt_reg <= beat_cnt_next;
      lock_idx_reg <= lock_idx_next;
      if (fire) begin
        last_grant_reg <= chosen;
      end
    end
  end

endmodule

// File: tb/tb_grant_burst_scheduler.sv
// tb_grant_burst_scheduler
//   Directed stimulus with hand-computed expected grants. Each step pushes
//   the expected transfer into a queue; a negedge monitor pops and compares
//   whenever the DUT fires. Non-transfer cycles are checked inline.
module tb_grant_burst_scheduler;

  localparam int N = 4;
  localparam int W = 76;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N-1:0]   in_multibeat;
  logic [N*W-1:0] in_payload;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_payload;
  logic [1:0]     out_chosen;
  logic           out_locked;

  int checks  = 0;
  int errors  = 0;
  int step_no = 0;

  typedef struct {
    int         ch;
    logic [W-1:0] pl;
    logic       lk;
  } exp_t;

  exp_t exp_q[$];

  grant_burst_scheduler #(
    .N_IN(N), .PAYLOAD_W(W), .BEATS(8), .MAX_WAIT(15)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_multibeat (in_multibeat),
    .in_payload   (in_payload),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_payload  (out_payload),
    .out_chosen   (out_chosen),
    .out_locked   (out_locked)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pl_of(input int i, input int s);
    return {4'(i + 1), 72'(s)};
  endfunction

  // One cycle of stimulus. ch/v/lk are the hand-derived chosen index,
  // out_valid and out_locked for this cycle.
  task automatic step(input logic [3:0] vld, input logic [3:0] mb, input logic rdy,
                      input int ch, input logic v, input logic lk);
    exp_t e;
    logic [3:0] exp_rdy;
    @(posedge clk);
    #1;
    step_no++;
    reset        = 1'b0;
    in_valid     = vld;
    in_multibeat = mb;
    out_ready    = rdy;
    for (int i = 0; i < N; i++) in_payload[i*W +: W] = pl_of(i, step_no);
    if (v && rdy) begin
      e.ch = ch;
      e.pl = pl_of(ch, step_no);
      e.lk = lk;
      exp_q.push_back(e);
    end
    #1;
    exp_rdy = rdy ? 4'(1 << ch) : 4'b0000;
    checks++;
    if (out_valid !== v) begin
      errors++;
      $display("FAIL out_valid step %0d: got %b want %b", step_no, out_valid, v);
    end
    checks++;
    if (out_locked !== lk) begin
      errors++;
      $display("FAIL out_locked step %0d: got %b want %b", step_no, out_locked, lk);
    end
    checks++;
    if (in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL in_ready step %0d: got %b want %b", step_no, in_ready, exp_rdy);
    end
    if (!(v && rdy)) begin
      checks++;
      if (out_chosen !== 2'(ch)) begin
        errors++;
        $display("FAIL out_chosen step %0d: got %0d want %0d", step_no, out_chosen, ch);
      end
    end
  endtask

  // Monitor: compare every transfer against the scoreboard.
  initial begin
    exp_t m;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_fire step %0d: got chosen %0d want no transfer",
                   step_no, out_chosen);
        end else begin
          m = exp_q.pop_front();
          if (out_chosen !== 2'(m.ch) || out_payload !== m.pl || out_locked !== m.lk) begin
            errors++;
            $display("FAIL transfer step %0d: got ch=%0d lk=%b pl=%h want ch=%0d lk=%b pl=%h",
                     step_no, out_chosen, out_locked, out_payload, m.ch, m.lk, m.pl);
          end else begin
            $display("step %0d: grant ch=%0d locked=%b payload=%h",
                     step_no, out_chosen, out_locked, out_payload);
          end
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset        = 1'b1;
    in_valid     = '0;
    in_multibeat = '0;
    in_payload   = '0;
    out_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state: nothing valid, chosen = N-1
    step(4'h0, 4'h0, 1'b0, 3, 1'b0, 1'b0);

    // Round-robin 0,1,2,3,0
    step(4'hF, 4'h0, 1'b1, 0, 1'b1, 1'b0);
    step(4'hF, 4'h0, 1'b1, 1, 1'b1, 1'b0);
    step(4'hF, 4'h0, 1'b1, 2, 1'b1, 1'b0);
    step(4'hF, 4'h0, 1'b1, 3, 1'b1, 1'b0);
    step(4'hF, 4'h0, 1'b1, 0, 1'b1, 1'b0);
    step(4'h0, 4'h0, 1'b0, 0, 1'b0, 1'b0);

    // Burst lock: req1 eight beats, req2 waits, multibeat ignored while locked
    step(4'h6, 4'h2, 1'b1, 1, 1'b1, 1'b0);
    repeat (7) step(4'h6, 4'h0, 1'b1, 1, 1'b1, 1'b1);
    step(4'h6, 4'h0, 1'b1, 2, 1'b1, 1'b0);
    step(4'h0, 4'h0, 1'b0, 2, 1'b0, 1'b0);

    // Lock stall: req0 burst, drops valid after beat 4 for 3 cycles
    step(4'h9, 4'h1, 1'b1, 3, 1'b1, 1'b0);
    step(4'h9, 4'h1, 1'b1, 0, 1'b1, 1'b0);
    repeat (3) step(4'h9, 4'h0, 1'b1, 0, 1'b1, 1'b1);
    repeat (3) step(4'h8, 4'h0, 1'b1, 0, 1'b0, 1'b1);
    repeat (4) step(4'h9, 4'h0, 1'b1, 0, 1'b1, 1'b1);
    step(4'h9, 4'h0, 1'b1, 3, 1'b1, 1'b0);
    step(4'h0, 4'h0, 1'b0, 3, 1'b0, 1'b0);

    // Starvation: req1, req3 saturate under backpressure; then starving
    // req3 beats round-robin candidate req2
    repeat (20) step(4'hA, 4'h0, 1'b0, 1, 1'b1, 1'b0);
    step(4'hE, 4'h0, 1'b1, 1, 1'b1, 1'b0);
    step(4'hE, 4'h0, 1'b1, 3, 1'b1, 1'b0);
    step(4'hE, 4'h0, 1'b1, 1, 1'b1, 1'b0);
    step(4'hE, 4'h0, 1'b1, 2, 1'b1, 1'b0);
    step(4'h0, 4'h0, 1'b0, 2, 1'b0, 1'b0);

    // Backpressure: last_grant must stay 2 so req3 wins on release
    repeat (10) step(4'h8, 4'h0, 1'b0, 3, 1'b1, 1'b0);
    step(4'hB, 4'h0, 1'b1, 3, 1'b1, 1'b0);
    step(4'hB, 4'h0, 1'b1, 0, 1'b1, 1'b0);
    step(4'hB, 4'h0, 1'b1, 1, 1'b1, 1'b0);
    step(4'h0, 4'h0, 1'b0, 1, 1'b0, 1'b0);

    // Reset at beat 5 of a req1 burst: lock dropped, req0 wins
    step(4'h2, 4'h2, 1'b1, 1, 1'b1, 1'b0);
    repeat (4) step(4'h2, 4'h0, 1'b1, 1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    reset        = 1'b1;
    out_ready    = 1'b0;
    in_valid     = 4'h3;
    in_multibeat = 4'h0;
    step(4'h3, 4'h0, 1'b1, 0, 1'b1, 1'b0);
    step(4'h3, 4'h0, 1'b1, 1, 1'b1, 1'b0);
    step(4'h3, 4'h0, 1'b1, 0, 1'b1, 1'b0);
    step(4'h0, 4'h0, 1'b0, 0, 1'b0, 1'b0);

    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_transfers: got %0d left want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
